// File: rtl/arcade_input_mapper_if.sv
// Keyboard/joystick inputs and per-player control outputs of the input mapper.
// Master drives ps2/joystick/config and samples the mapped controls.
interface arcade_input_mapper_if #(
    parameter int NBTN = 2
);
    logic [64:0]     ps2_key;
    logic [15:0]     joy0;
    logic [15:0]     joy1;
    logic [1:0]      rotate;
    logic            autofire_en;
    logic [3:0]      p1_dir;
    logic [3:0]      p2_dir;
    logic [NBTN-1:0] p1_btn;
    logic [NBTN-1:0] p2_btn;
    logic            start1;
    logic            start2;
    logic            coin;

    modport master (
        output ps2_key, joy0, joy1, rotate, autofire_en,
        input  p1_dir, p2_dir, p1_btn, p2_btn, start1, start2, coin
    );

    modport slave (
        input  ps2_key, joy0, joy1, rotate, autofire_en,
        output p1_dir, p2_dir, p1_btn, p2_btn, start1, start2, coin
    );
endinterface

// File: rtl/arcade_input_mapper.sv
// Merges PS/2 keys and two joysticks into rotated, SOCD-cleaned arcade controls; no backpressure.
// All outputs registered: one clk_sys cycle from input (or key event) to output.
module arcade_input_mapper #(
    parameter int          NBTN        = 2,
    parameter logic [23:0] COIN_CYCLES = 24'd2400000,
    parameter logic [23:0] AF_CYCLES   = 24'd1000000
) (
    input logic                  clk_sys,
    input logic                  reset,
    arcade_input_mapper_if.slave io
);
    typedef enum logic [1:0] {COIN_IDLE, COIN_PULSE, COIN_WAIT_REL} coin_state_t;

    // Key state uses the joystick bit layout so both can be OR-ed directly.
    logic [10:0]     key_q, key_n;
    logic            toggle_q;
    logic            key_evt, key_press;
    logic [10:0]     raw_p1, raw_p2;
    logic            coin_req, coin_req_q;
    coin_state_t     coin_state, coin_state_n;
    logic [23:0]     coin_cnt, coin_cnt_n;
    logic [23:0]     af_cnt, af_cnt_n;
    logic            af_phase, af_phase_n;
    logic [1:0]      fire0_q;
    logic            af_sync;
    logic [NBTN-1:0] btn1_n, btn2_n;
    logic            unused_bits;

    assign key_evt   = (io.ps2_key[64] != toggle_q) && (io.ps2_key[63:24] == 40'd0);
    assign key_press = (io.ps2_key[15:8] != 8'hF0);

    always_comb begin
        key_n = key_q;
        if (key_evt) begin
            case (io.ps2_key[7:0])
                8'h75:        key_n[3]  = key_press;
                8'h72:        key_n[2]  = key_press;
                8'h6B:        key_n[1]  = key_press;
                8'h74:        key_n[0]  = key_press;
                8'h29, 8'h14: key_n[4]  = key_press;
                8'h11:        if (NBTN > 1) key_n[5] = key_press;
                8'h12:        if (NBTN > 2) key_n[6] = key_press;
                8'h1A:        if (NBTN > 3) key_n[7] = key_press;
                8'h05:        key_n[8]  = key_press;
                8'h06:        key_n[9]  = key_press;
                8'h2E:        key_n[10] = key_press;
                default:      ;
            endcase
        end
    end

    assign raw_p1   = key_n | io.joy0[10:0];
    assign raw_p2   = io.joy1[10:0];
    assign coin_req = raw_p1[10] | raw_p2[10];

    // d = {up,down,left,right}; mode names where each physical input direction ends up.
    function automatic logic [3:0] orient(input logic [3:0] d, input logic [1:0] rot);
        logic [3:0] o;
        case (rot)
            2'd1:    o = {d[0], d[1], d[3], d[2]};
            2'd2:    o = {d[2], d[3], d[0], d[1]};
            2'd3:    o = {d[1], d[0], d[2], d[3]};
            default: o = d;
        endcase
        if (o[3] && o[2]) o[3:2] = 2'b00;
        if (o[1] && o[0]) o[1:0] = 2'b00;
        return o;
    endfunction

    // A fresh fire0 press restarts the autofire phase so the first shot is immediate.
    assign af_sync = (raw_p1[4] && !fire0_q[0]) || (raw_p2[4] && !fire0_q[1]);

    always_comb begin
        af_cnt_n   = af_cnt + 24'd1;
        af_phase_n = af_phase;
        if (af_sync) begin
            af_cnt_n   = 24'd0;
            af_phase_n = 1'b1;
        end else if (af_cnt >= AF_CYCLES - 24'd1) begin
            af_cnt_n   = 24'd0;
            af_phase_n = ~af_phase;
        end
        btn1_n = raw_p1[4 +: NBTN];
        btn2_n = raw_p2[4 +: NBTN];
        if (io.autofire_en) begin
            btn1_n[0] = raw_p1[4] & af_phase_n;
            btn2_n[0] = raw_p2[4] & af_phase_n;
        end
    end

    always_comb begin
        coin_state_n = coin_state;
        coin_cnt_n   = coin_cnt;
        case (coin_state)
            COIN_IDLE: begin
                if (coin_req && !coin_req_q) begin
                    coin_state_n = COIN_PULSE;
                    coin_cnt_n   = COIN_CYCLES - 24'd1;
                end
            end
            COIN_PULSE: begin
                if (coin_cnt == 24'd0) coin_state_n = coin_req ? COIN_WAIT_REL : COIN_IDLE;
                else                   coin_cnt_n   = coin_cnt - 24'd1;
            end
            COIN_WAIT_REL: if (!coin_req) coin_state_n = COIN_IDLE;
            default:       coin_state_n = COIN_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            coin_state <= COIN_IDLE;
            coin_cnt   <= 24'd0;
        end else begin
            coin_state <= coin_state_n;
            coin_cnt   <= coin_cnt_n;
        end
    end

    // Under reset the edge history tracks live inputs, so held coin/toggle are not seen as new.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            key_q      <= '0;
            toggle_q   <= io.ps2_key[64];
            coin_req_q <= io.joy0[10] | io.joy1[10];
            af_cnt     <= 24'd0;
            af_phase   <= 1'b1;
            fire0_q    <= 2'b00;
            io.p1_dir  <= 4'd0;
            io.p2_dir  <= 4'd0;
            io.p1_btn  <= '0;
            io.p2_btn  <= '0;
            io.start1  <= 1'b0;
            io.start2  <= 1'b0;
            io.coin    <= 1'b0;
        end else begin
            key_q      <= key_n;
            toggle_q   <= io.ps2_key[64];
            coin_req_q <= coin_req;
            af_cnt     <= af_cnt_n;
            af_phase   <= af_phase_n;
            fire0_q    <= {raw_p2[4], raw_p1[4]};
            io.p1_dir  <= orient(raw_p1[3:0], io.rotate);
            io.p2_dir  <= orient(raw_p2[3:0], io.rotate);
            io.p1_btn  <= btn1_n;
            io.p2_btn  <= btn2_n;
            io.start1  <= raw_p1[8] | raw_p2[8];
            io.start2  <= raw_p1[9] | raw_p2[9];
            io.coin    <= (coin_state_n == COIN_PULSE);
        end
    end

    assign unused_bits = ^{io.joy0[15:11], io.joy1[15:11], io.ps2_key[23:16], raw_p1[7:4], raw_p2[7:4]};
endmodule

// File: tb/tb_arcade_input_mapper.sv
// Self-checking bench for arcade_input_mapper: direction table, directed corner sequences, random vs model.
module tb_arcade_input_mapper;
    localparam int NBTN   = 2;
    localparam int COIN_C = 5;
    localparam int AF_C   = 4;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    arcade_input_mapper_if #(.NBTN(NBTN)) io ();

    arcade_input_mapper #(
        .NBTN(NBTN), .COIN_CYCLES(24'd5), .AF_CYCLES(24'd4)
    ) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .io     (io)
    );

    int errors = 0;
    int checks = 0;

    // Destination direction for each source direction (0 right,1 left,2 down,3 up) per rotate mode.
    int dir_map [4][4] = '{'{0, 1, 2, 3}, '{3, 2, 0, 1}, '{1, 0, 3, 2}, '{2, 3, 1, 0}};

    typedef struct {logic [7:0] code; int idx;} key_t;
    key_t keymap [12];
    logic [7:0] pool [14];

    typedef struct {logic [1:0] rot; logic [15:0] j0; logic [15:0] j1; logic [3:0] p1; logic [3:0] p2;} vec_t;
    vec_t vecs [9];

    logic [10:0]     m_key;
    logic            m_tog, m_req_q;
    int              m_pulse_left, m_af_n;
    logic [1:0]      m_fire_q;
    logic [3:0]      e_p1_dir, e_p2_dir;
    logic [NBTN-1:0] e_p1_btn, e_p2_btn;
    logic            e_start1, e_start2, e_coin;

    function automatic logic [3:0] model_dir(input logic [3:0] in, input logic [1:0] rot);
        logic [3:0] o;
        o = '0;
        for (int i = 0; i < 4; i++) if (in[i]) o[dir_map[rot][i]] = 1'b1;
        if (o[3] && o[2]) o[3:2] = 2'b00;
        if (o[1] && o[0]) o[1:0] = 2'b00;
        return o;
    endfunction

    task automatic model_update();
        logic [10:0] r1, r2;
        logic req, rise;
        if (reset) begin
            m_key = '0; m_tog = io.ps2_key[64]; m_req_q = io.joy0[10] | io.joy1[10];
            m_pulse_left = 0; m_af_n = 0; m_fire_q = 2'b00;
            e_p1_dir = '0; e_p2_dir = '0; e_p1_btn = '0; e_p2_btn = '0;
            e_start1 = 1'b0; e_start2 = 1'b0; e_coin = 1'b0;
        end else begin
            if (io.ps2_key[64] != m_tog && io.ps2_key[63:24] == 40'd0)
                for (int k = 0; k < 12; k++)
                    if (keymap[k].code == io.ps2_key[7:0] &&
                        (keymap[k].idx < 4 || keymap[k].idx >= 8 || keymap[k].idx - 4 < NBTN))
                        m_key[keymap[k].idx] = (io.ps2_key[15:8] != 8'hF0);
            m_tog = io.ps2_key[64];
            r1 = m_key | io.joy0[10:0];
            r2 = io.joy1[10:0];
            req = r1[10] | r2[10];
            if (m_pulse_left > 0) m_pulse_left--;
            else if (req && !m_req_q) m_pulse_left = COIN_C;
            m_req_q = req;
            rise = (r1[4] && !m_fire_q[0]) || (r2[4] && !m_fire_q[1]);
            m_af_n = rise ? 0 : m_af_n + 1;
            m_fire_q = {r2[4], r1[4]};
            e_p1_dir = model_dir(r1[3:0], io.rotate);
            e_p2_dir = model_dir(r2[3:0], io.rotate);
            e_p1_btn = r1[4 +: NBTN];
            e_p2_btn = r2[4 +: NBTN];
            if (io.autofire_en) begin
                e_p1_btn[0] = r1[4] && ((m_af_n / AF_C) % 2 == 0);
                e_p2_btn[0] = r2[4] && ((m_af_n / AF_C) % 2 == 0);
            end
            e_start1 = r1[8] | r2[8];
            e_start2 = r1[9] | r2[9];
            e_coin = (m_pulse_left > 0);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_update();
        #1;
        check("model", 32'({io.p1_dir, io.p2_dir, io.p1_btn, io.p2_btn, io.start1, io.start2, io.coin}),
              32'({e_p1_dir, e_p2_dir, e_p1_btn, e_p2_btn, e_start1, e_start2, e_coin}));
    endtask

    task automatic ps2_event(input logic [23:0] code, input logic [39:0] hi);
        io.ps2_key = {~io.ps2_key[64], hi, code};
    endtask

    initial begin
        int hi, rises, first;
        logic prev;
        logic [15:0] pat;
        logic [7:0] code;
        logic ext, rel;

        keymap = '{'{8'h75, 3}, '{8'h72, 2}, '{8'h6B, 1}, '{8'h74, 0}, '{8'h29, 4}, '{8'h14, 4},
                   '{8'h11, 5}, '{8'h12, 6}, '{8'h1A, 7}, '{8'h05, 8}, '{8'h06, 9}, '{8'h2E, 10}};
        pool = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h11, 8'h12, 8'h1A, 8'h05, 8'h06, 8'h2E, 8'h1C, 8'h76};
        vecs = '{'{2'd0, 16'h0003, 16'h0000, 4'b0000, 4'b0000},
                 '{2'd0, 16'h000B, 16'h0000, 4'b1000, 4'b0000},
                 '{2'd1, 16'h0000, 16'h0002, 4'b0000, 4'b0100},
                 '{2'd2, 16'h0000, 16'h0002, 4'b0000, 4'b0001},
                 '{2'd3, 16'h0000, 16'h0002, 4'b0000, 4'b1000},
                 '{2'd1, 16'h0008, 16'h0000, 4'b0010, 4'b0000},
                 '{2'd3, 16'h0001, 16'h0000, 4'b0100, 4'b0000},
                 '{2'd2, 16'h000C, 16'h0000, 4'b0000, 4'b0000},
                 '{2'd1, 16'h0009, 16'h0000, 4'b1010, 4'b0000}};

        io.ps2_key = '0; io.joy0 = '0; io.joy1 = '0; io.rotate = 2'd0; io.autofire_en = 1'b0;
        reset = 1'b1;
        step(); step();
        check("reset_outputs", 32'({io.p1_dir, io.p2_dir, io.p1_btn, io.p2_btn, io.start1, io.start2, io.coin}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            io.rotate = vecs[i].rot; io.joy0 = vecs[i].j0; io.joy1 = vecs[i].j1;
            step();
            check("vec_p1_dir", 32'(io.p1_dir), 32'(vecs[i].p1));
            check("vec_p2_dir", 32'(io.p2_dir), 32'(vecs[i].p2));
        end

        io.rotate = 2'd0; io.joy0 = '0; io.joy1 = '0;
        step();
        ps2_event(24'h00E075, 40'd0); step();
        check("kbd_up_press", 32'(io.p1_dir), 32'b1000);
        ps2_event(24'hE0F075, 40'd0); step();
        check("kbd_up_release", 32'(io.p1_dir), 32'b0000);
        ps2_event(24'h00E075, 40'h0000000001); step();
        check("kbd_seq_ignored", 32'(io.p1_dir), 32'b0000);
        io.ps2_key[23:0] = 24'h00E072; step();
        check("kbd_no_toggle", 32'(io.p1_dir), 32'b0000);
        ps2_event(24'h000029, 40'd0); io.joy0 = 16'h0008; step();
        check("same_cycle_dir", 32'(io.p1_dir), 32'b1000);
        check("same_cycle_btn", 32'(io.p1_btn), 32'b01);
        ps2_event(24'h00F029, 40'd0); io.joy0 = '0; step();
        ps2_event(24'h000012, 40'd0); step();
        check("fire_beyond_nbtn", 32'(io.p1_btn), 32'b00);
        ps2_event(24'h00F012, 40'd0); step();

        io.joy0 = 16'h0400; hi = 0; rises = 0; first = -1; prev = io.coin;
        for (int c = 0; c < 20; c++) begin
            step();
            if (io.coin) begin hi++; if (first < 0) first = c; end
            if (io.coin && !prev) rises++;
            prev = io.coin;
        end
        check("coin_len", 32'(hi), 32'(COIN_C));
        check("coin_pulses", 32'(rises), 32'd1);
        check("coin_latency", 32'(first), 32'd0);
        io.joy0 = '0; repeat (3) step();
        io.joy0 = 16'h0400; hi = 0;
        for (int c = 0; c < 10; c++) begin step(); if (io.coin) hi++; end
        check("coin_len2", 32'(hi), 32'(COIN_C));
        io.joy0 = '0; repeat (6) step();

        io.autofire_en = 1'b1; repeat (3) step();
        io.joy0 = 16'h0010; pat = '0;
        for (int c = 0; c < 16; c++) begin step(); pat = {pat[14:0], io.p1_btn[0]}; end
        check("af_pattern", 32'(pat), 32'h0000F0F0);
        io.joy0 = '0; io.autofire_en = 1'b0; step();

        io.joy0 = 16'h0400; step(); step();
        check("coin_before_rst", 32'(io.coin), 32'd1);
        reset = 1'b1; ps2_event(24'h00E075, 40'd0); step();
        check("rst_coin_drop", 32'(io.coin), 32'd0);
        reset = 1'b0; hi = 0;
        for (int c = 0; c < 4; c++) begin step(); if (io.coin) hi++; end
        check("rst_no_coin_edge", 32'(hi), 32'd0);
        check("rst_no_key", 32'(io.p1_dir), 32'd0);
        io.joy0 = '0; step();
        io.joy0 = 16'h0400; step();
        check("coin_after_rst", 32'(io.coin), 32'd1);
        io.joy0 = '0; repeat (6) step();

        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) io.joy0 = 16'($urandom);
            if ($urandom_range(0, 3) == 0) io.joy1 = 16'($urandom);
            if ($urandom_range(0, 15) == 0) io.rotate = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) io.autofire_en = ~io.autofire_en;
            if ($urandom_range(0, 2) == 0) begin
                code = pool[$urandom_range(0, 13)];
                ext = (code == 8'h75 || code == 8'h72 || code == 8'h6B || code == 8'h74);
                rel = 1'($urandom_range(0, 1));
                ps2_event(rel ? {(ext ? 8'hE0 : 8'h00), 8'hF0, code} : {8'h00, (ext ? 8'hE0 : 8'h00), code},
                          ($urandom_range(0, 7) == 0) ? 40'h00E012E07C : 40'd0);
            end
            reset = ($urandom_range(0, 99) == 0);
            step();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
